// File: rtl/dl_pkg.sv
// Shared definitions for the dl_* pipeline library.
//   dl_skid_state_t : occupancy state of the two-entry skid buffer
//   DL_SKID_DEPTH   : number of beats the skid buffer can hold
package dl_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } dl_skid_state_t;

    localparam int DL_SKID_DEPTH = 2;

endpackage

// File: rtl/dl_reg_en_rst.sv
// Generic register with load enable and synchronous active-high clear.
//   clk : rising-edge clock
//   rst : synchronous clear to 0, takes priority over en
//   en  : load d on the next edge
//   d   : next value
//   q   : registered value
module dl_reg_en_rst #(
    parameter int NUM_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [NUM_BITS-1:0] d,
    output logic [NUM_BITS-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dl_skid_buf.sv
// Two-entry elastic stage with valid/ready on both sides. Every output is a
// decode of registered state, so no input reaches an output combinationally.
//   clk, rst          : clock and synchronous active-high reset
//   in_val/in_rdy     : producer handshake, in_data is the payload
//   out_val/out_rdy   : consumer handshake, out_data is the payload
//   count             : current occupancy (0..2)
//
// state | meaning
// EMPTY | nothing held, out_val=0, in_rdy=1
// BUSY  | one beat in main_q, out_val=1, in_rdy=1
// FULL  | main_q plus overflow beat in skid_q, out_val=1, in_rdy=0
module dl_skid_buf
    import dl_pkg::*;
#(
    parameter int NUM_BITS = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_val,
    output logic                in_rdy,
    input  logic [NUM_BITS-1:0] in_data,
    output logic                out_val,
    input  logic                out_rdy,
    output logic [NUM_BITS-1:0] out_data,
    output logic [1:0]          count
);

    dl_skid_state_t state_q;
    dl_skid_state_t state_d;

    logic                in_fire;
    logic                out_fire;
    logic                main_en;
    logic                main_from_skid;
    logic                skid_en;
    logic [NUM_BITS-1:0] main_d;
    logic [NUM_BITS-1:0] main_q;
    logic [NUM_BITS-1:0] skid_q;

    assign in_rdy   = (state_q != FULL);
    assign out_val  = (state_q != EMPTY);
    assign out_data = main_q;
    assign in_fire  = in_val & in_rdy;
    assign out_fire = out_val & out_rdy;

    always_comb begin
        case (state_q)
            EMPTY:   count = 2'd0;
            BUSY:    count = 2'd1;
            FULL:    count = 2'(DL_SKID_DEPTH);
            default: count = 2'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        main_from_skid = 1'b0;
        skid_en        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = BUSY;
                    main_en = 1'b1;
                end
            end
            BUSY: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    // consumer stalled: park the new beat behind main_q
                    state_d = FULL;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    state_d        = BUSY;
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    dl_reg_en_rst #(.NUM_BITS(NUM_BITS)) u_main (
        .clk (clk),
        .rst (rst),
        .en  (main_en),
        .d   (main_d),
        .q   (main_q)
    );

    dl_reg_en_rst #(.NUM_BITS(NUM_BITS)) u_skid (
        .clk (clk),
        .rst (rst),
        .en  (skid_en),
        .d   (in_data),
        .q   (skid_q)
    );

endmodule

// File: tb/tb_dl_skid_buf.sv
// Bench for dl_skid_buf: directed vector table followed by randomized
// handshakes checked against a queue-based reference.
module tb_dl_skid_buf;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_val;
    logic         in_rdy;
    logic [W-1:0] in_data;
    logic         out_val;
    logic         out_rdy;
    logic [W-1:0] out_data;
    logic [1:0]   count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dl_skid_buf #(.NUM_BITS(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_val   (in_val),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .out_data (out_data),
        .count    (count)
    );

    typedef struct {
        logic         rst;
        logic         iv;
        logic [W-1:0] id;
        logic         ordy;
        logic         e_ov;
        logic         e_ir;
        logic [1:0]   e_cnt;
        logic [W-1:0] e_od;
        string        name;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic iv, input logic [W-1:0] id,
                       input logic ordy, input logic ov, input logic ir,
                       input logic [1:0] cnt, input logic [W-1:0] od,
                       input string name);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_ov = ov; v.e_ir = ir; v.e_cnt = cnt; v.e_od = od; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference for the random phase: beats held, oldest first.
    logic [W-1:0] model_q[$];

    initial begin
        rst = 1'b1; in_val = 1'b0; in_data = '0; out_rdy = 1'b0;

        // rst iv data ordy | out_val in_rdy count out_data
        add(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, "reset0");
        add(1, 0, 8'h00, 0, 0, 1, 0, 8'h00, "reset1");
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, "idle");
        for (int i = 1; i <= 8; i++)
            add(0, 1, 8'(i), 1, 1, 1, 1, 8'(i), "stream");
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'h08, "stream_end");
        add(0, 1, 8'hA1, 0, 1, 1, 1, 8'hA1, "stall_busy");
        add(0, 1, 8'hB2, 0, 1, 0, 2, 8'hA1, "stall_full");
        for (int i = 0; i < 3; i++)
            add(0, 1, 8'hC3, 0, 1, 0, 2, 8'hA1, "full_ignore");
        add(0, 0, 8'h00, 1, 1, 1, 1, 8'hB2, "drain1");
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'hB2, "drain2");
        add(0, 1, 8'hD4, 0, 1, 1, 1, 8'hD4, "rst_busy");
        add(0, 1, 8'hE5, 0, 1, 0, 2, 8'hD4, "rst_full");
        add(1, 1, 8'hF6, 1, 0, 1, 0, 8'h00, "rst_mid");
        add(0, 0, 8'h00, 1, 0, 1, 0, 8'h00, "rst_after");

        foreach (vecs[i]) begin
            rst = vecs[i].rst; in_val = vecs[i].iv;
            in_data = vecs[i].id; out_rdy = vecs[i].ordy;
            @(posedge clk); #1;
            check({vecs[i].name, "_out_val"},  32'(out_val),  32'(vecs[i].e_ov));
            check({vecs[i].name, "_in_rdy"},   32'(in_rdy),   32'(vecs[i].e_ir));
            check({vecs[i].name, "_count"},    32'(count),    32'(vecs[i].e_cnt));
            check({vecs[i].name, "_out_data"}, 32'(out_data), 32'(vecs[i].e_od));
        end

        // Hand sequence: in FULL, toggling out_rdy=0 keeps the head beat
        // stable, then a single out_rdy pulse releases exactly one beat.
        rst = 0; in_val = 1; out_rdy = 0; in_data = 8'h11;
        @(posedge clk); #1; in_data = 8'h22;
        @(posedge clk); #1; in_val = 0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("hold_out_data", 32'(out_data), 32'h11);
            check("hold_count", 32'(count), 32'd2);
        end
        out_rdy = 1;
        @(posedge clk); #1; out_rdy = 0;
        check("pulse_out_data", 32'(out_data), 32'h22);
        @(posedge clk); #1;
        check("pulse_count", 32'(count), 32'd1);

        // Randomized phase, starting from a fresh reset.
        rst = 1; in_val = 0; out_rdy = 0;
        @(posedge clk); #1;
        rst = 0;
        model_q.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic iv, ordy, ifire, ofire;
            logic [W-1:0] d;
            check("rnd_in_rdy",  32'(in_rdy),  32'(model_q.size() < 2));
            check("rnd_out_val", 32'(out_val), 32'(model_q.size() > 0));
            check("rnd_count",   32'(count),   32'(model_q.size()));
            if (count > 2'd2) check("rnd_count_max", 32'(count), 32'd2);
            if (model_q.size() > 0)
                check("rnd_out_data", 32'(out_data), 32'(model_q[0]));
            iv   = ($urandom_range(0, 99) < 60);
            ordy = ($urandom_range(0, 99) < 55);
            d    = 8'($urandom);
            in_val = iv; out_rdy = ordy; in_data = d;
            ifire = iv && (model_q.size() < 2);
            ofire = ordy && (model_q.size() > 0);
            @(posedge clk); #1;
            if (ofire) void'(model_q.pop_front());
            if (ifire) model_q.push_back(d);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dl_skid_buf.md
# dl_skid_buf

Two-entry elastic pipeline stage with a valid/ready handshake on both sides. It sits directly upstream of plain pipeline registers in the design library and breaks every combinational path between producer and consumer: the ready, valid and data paths. It sustains full throughput of one transfer per cycle. When the consumer stalls, it absorbs the one in-flight beat without dropping or duplicating data.

## Interface
- `NUM_BITS`, default 1: width of the data payload.

- `clk`  input  1  rising-edge clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `in_val`  input  1  producer has valid data on `in_data`.
- `in_rdy`  output  1  buffer can accept a beat this cycle.
- `in_data`  input  NUM_BITS  producer payload.
- `out_val`  output  1  `out_data` holds a valid beat.
- `out_rdy`  input  1  consumer accepts a beat this cycle.
- `out_data`  output  NUM_BITS  payload to the consumer.
- `count`  output  2  occupancy: 0, 1 or 2.

## Operation
- Fire definitions:
  - in-fire = `in_val & in_rdy`.
  - out-fire = `out_val & out_rdy`.
- Storage: main register `main_q` drives `out_data`; skid register `skid_q` holds the overflow beat.
- States:
  - EMPTY: count 0, `out_val`=0, `in_rdy`=1.
  - BUSY: count 1, `out_val`=1, `in_rdy`=1.
  - FULL: count 2, `out_val`=1, `in_rdy`=0.
- EMPTY transitions:
  - in-fire → BUSY, `main_q`←`in_data`.
  - Otherwise hold.
- BUSY transitions:
  - in-fire and out-fire → BUSY, `main_q`←`in_data`.
  - in-fire only → FULL, `skid_q`←`in_data`.
  - out-fire only → EMPTY.
  - Neither → hold.
- FULL transitions:
  - out-fire → BUSY, `main_q`←`skid_q`.
  - Otherwise hold.
  - `in_val` is ignored in FULL.
- Outputs are pure decodes of registered state and storage:
  - `in_rdy` = (state != FULL).
  - `out_val` = (state != EMPTY).
  - `count` follows the state.
  - No combinational path from any input to any output.
- Ordering: beats leave in exactly the order accepted. No loss, no duplication.
- `out_data` and `out_val` stay stable while `out_val`=1 and `out_rdy`=0.
- `out_rdy` may toggle freely. `in_val` may drop without a transfer.
- Illegal state encodings recover to EMPTY on the next edge.

## Timing
- Reset: on a rising edge with `rst`=1:
  - State becomes EMPTY.
  - `main_q`, `skid_q` become 0.
  - Therefore `out_val`=0, `in_rdy`=1, `count`=0, `out_data`=0.
  - `rst` overrides any concurrent fire.
- Reset mid-operation: any buffered beats are discarded. No out-fire is credited for the reset edge.
- Latency: a beat accepted at edge N is visible on `out_data` with `out_val`=1 after edge N.
  - It can be consumed at edge N+1 at the earliest.
- Throughput:
  - 1 beat/cycle in BUSY when `out_rdy`=1 continuously.
  - After a stall, at most 2 beats are held. Draining FULL→BUSY→EMPTY takes 2 out-fires.
- `in_rdy` deasserts the cycle after entering FULL. It reasserts the cycle after the first out-fire from FULL.
- Simultaneous in-fire and out-fire in FULL cannot occur, because `in_rdy`=0 in FULL.

## Structure
- Shared package `dl_pkg` gains:
  - the enum typedef `dl_skid_state_t` (EMPTY, BUSY, FULL), 2-bit encoding;
  - the constant `DL_SKID_DEPTH = 2`.
- Sub-module `dl_reg_en_rst`: `NUM_BITS`-wide register with load enable and synchronous active-high reset to 0.
  - Instantiated twice, for `main_q` and `skid_q`.
  - Reusable by other library stages.
- Next-state and load-enable logic live in a single `always_comb` block. The state register is its own `always_ff`.

## Test plan
- Reset, then idle: hold `rst`=1 for 2 cycles, then release with `in_val`=0 → `out_val`=0, `in_rdy`=1, `count`=0, `out_data`=0.
- Streaming: `out_rdy`=1, send 0x01..0x08 back-to-back with `NUM_BITS`=8.
  - Outputs 0x01..0x08 on consecutive cycles, each one cycle after acceptance.
  - `count` stays 1; `in_rdy` never drops.
- Stall absorb:
  - BUSY holding 0xA1, `out_rdy`=0, in-fire 0xB2 → FULL, `in_rdy`=0, `out_data`=0xA1.
  - With `in_val`=1 and data 0xC3 held for 3 cycles: 0xC3 is not accepted.
- Drain:
  - From FULL, set `out_rdy`=1 → outputs 0xA1 then 0xB2.
  - `count` goes 2→1→0; `in_rdy` returns to 1 after the first out-fire.
- Reset mid-operation:
  - Assert `rst` in FULL with a concurrent `in_val`=1 → next cycle EMPTY, `out_val`=0, no beat emitted.
- Randomized `in_val`/`out_rdy` over 10k cycles against a scoreboard queue:
  - Output sequence equals input sequence.
  - `count` never exceeds 2.
